// File: rtl/rv_fetch.sv
// rv_fetch: single-issue instruction fetch stage with a one-entry hold buffer.
//
// The stage tracks three things:
//   - pc_q: the next sequential fetch address.
//   - s1:   the request in flight; its data is on imem_instr_i this cycle.
//   - hold: a one-entry buffer that catches the s1 word when decode stalls.
// Redirects from execute take effect in the same cycle on imem_pc_o, so the
// target instruction is presented the following cycle.
//
// Optional feature macro: RV_FETCH_MISALIGN_EN
//   Defined:   a redirect to a target with bits [1:0] != 0 flushes the stage,
//              pulses misalign_o for one cycle and halts fetch until the next
//              aligned redirect.
//   Undefined: redirect target bits [1:0] are forced to zero and the
//              misalign_o port does not exist.
module rv_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic [63:0] imem_pc_o,
  input  logic [31:0] imem_instr_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [63:0] id_pc_o,
  output logic [31:0] id_instr_o
`ifdef RV_FETCH_MISALIGN_EN
  ,
  output logic        misalign_o
`endif
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [63:0] pc_q, pc_d;
  logic        s1_valid_q, s1_valid_d;
  logic [63:0] s1_pc_q, s1_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [63:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;

  // --------------------------------------------------------------------------
  // Redirect target handling
  // --------------------------------------------------------------------------
  logic [63:0] redirect_tgt;
  logic        redirect_bad;   // redirect whose target is not word aligned
  logic        halted;         // fetch is stopped waiting for a good redirect

  // The low two bits never reach memory; the masked form also keeps every
  // bit of the input in use when the misalign check is compiled out.
  assign redirect_tgt = redirect_pc_i & ~64'h3;

`ifdef RV_FETCH_MISALIGN_EN
  logic halt_q, halt_d;
  logic misalign_q, misalign_d;

  assign redirect_bad = redirect_i & (redirect_pc_i[1:0] != 2'b00);
  assign halted       = halt_q;
`else
  assign redirect_bad = 1'b0;
  assign halted       = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Presentation toward decode
  // --------------------------------------------------------------------------
  logic [63:0] present_pc;
  logic [31:0] present_instr;
  logic        present_valid;
  logic        xfer;          // an instruction is handed to decode this cycle
  logic        hold_leaves;   // the hold entry is the one transferring
  logic        s1_leaves;     // the s1 entry transfers directly
  logic        stall_full;    // both entries occupied and decode not taking
  logic        issue;         // a new sequential fetch goes out this cycle

  // The hold entry is always older than s1, so it is presented first.
  assign present_pc    = hold_valid_q ? hold_pc_q    : s1_pc_q;
  assign present_instr = hold_valid_q ? hold_instr_q : imem_instr_i;
  assign present_valid = (hold_valid_q | s1_valid_q) & ~redirect_i;

  assign xfer        = present_valid & id_ready_i;
  assign hold_leaves = hold_valid_q & xfer;
  assign s1_leaves   = ~hold_valid_q & s1_valid_q & xfer;

  // With both slots full and decode stalled there is nowhere to put another
  // word, so the in-flight address is replayed instead of advancing.
  assign stall_full = hold_valid_q & s1_valid_q & ~id_ready_i;
  assign issue      = ~halted & ~stall_full;

  // Outputs are forced quiet while reset is asserted, independent of state.
  assign id_valid_o = ~rst & present_valid;
  assign id_pc_o    = rst ? 64'h0 : present_pc;
  assign id_instr_o = rst ? 32'h0 : present_instr;

`ifdef RV_FETCH_MISALIGN_EN
  assign misalign_o = ~rst & misalign_q;
`endif

  // Next-state and memory address selection; redirect overrides stall/replay.
  always_comb begin
    pc_d         = pc_q;
    s1_valid_d   = s1_valid_q;
    s1_pc_d      = s1_pc_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    imem_pc_o    = pc_q;
`ifdef RV_FETCH_MISALIGN_EN
    halt_d       = halt_q;
    misalign_d   = 1'b0;
`endif

    if (redirect_i) begin
      // Anything already fetched belongs to the wrong path.
      hold_valid_d = 1'b0;
      if (redirect_bad) begin
        // Flush and stop; the address to memory stays at pc_q.
        s1_valid_d = 1'b0;
        imem_pc_o  = pc_q;
`ifdef RV_FETCH_MISALIGN_EN
        halt_d     = 1'b1;
        misalign_d = 1'b1;
`endif
      end else begin
        imem_pc_o  = redirect_tgt;
        s1_valid_d = 1'b1;
        s1_pc_d    = redirect_tgt;
        pc_d       = redirect_tgt + 64'd4;
`ifdef RV_FETCH_MISALIGN_EN
        halt_d     = 1'b0;
`endif
      end
    end else begin
      // Address side: new fetch, idle while halted, or replay of s1.
      if (issue) begin
        imem_pc_o  = pc_q;
        s1_valid_d = 1'b1;
        s1_pc_d    = pc_q;
        pc_d       = pc_q + 64'd4;
      end else if (halted) begin
        imem_pc_o  = pc_q;
        s1_valid_d = 1'b0;
      end else begin
        // Memory re-delivers the same word next cycle; s1 stays as is.
        imem_pc_o  = s1_pc_q;
      end

      // Hold side: capture the s1 word if it is not consumed now and the
      // hold slot is free (or is being freed by this cycle's transfer).
      if (s1_valid_q && !s1_leaves && (!hold_valid_q || hold_leaves)) begin
        hold_valid_d = 1'b1;
        hold_pc_d    = s1_pc_q;
        hold_instr_d = imem_instr_i;
      end else if (hold_leaves) begin
        hold_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset that discards all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      s1_valid_q   <= 1'b0;
      s1_pc_q      <= 64'h0;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= 64'h0;
      hold_instr_q <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      s1_valid_q   <= s1_valid_d;
      s1_pc_q      <= s1_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

`ifdef RV_FETCH_MISALIGN_EN
  // Halt flag and one-cycle misalign pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      halt_q     <= halt_d;
      misalign_q <= misalign_d;
    end
  end
`endif

endmodule

// File: tb/tb_rv_fetch.sv
// Directed testbench for rv_fetch (RESET_PC = 0x100).
// Inputs change on the falling edge; outputs are checked 1 time unit later,
// well away from the rising edge. The instruction memory returns a word
// derived from its address one cycle after the address is presented.
module tb_rv_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = 64'h0;
  logic [63:0] imem_pc_o;
  logic [31:0] imem_instr_i;
  logic        id_valid_o;
  logic        id_ready_i = 1'b1;
  logic [63:0] id_pc_o;
  logic [31:0] id_instr_o;
`ifdef RV_FETCH_MISALIGN_EN
  logic        misalign_o;
`endif

  int tests = 0;
  int fails = 0;

  rv_fetch #(.RESET_PC(64'h100)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_pc_o     (imem_pc_o),
    .imem_instr_i  (imem_instr_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o)
`ifdef RV_FETCH_MISALIGN_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  // Instruction word stored at a given address.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_instr_i <= word_at(imem_pc_o);

  // One cycle of stimulus: apply at the falling edge, settle, return.
  task automatic drive(input logic r, input logic rdy, input logic redir,
                       input logic [63:0] rpc);
    @(negedge clk);
    rst           = r;
    id_ready_i    = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
  endtask

  // Reset for two cycles, then the release cycle (fetch of RESET_PC issued).
  task automatic apply_reset();
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    drive(1'b0, 1'b1, 1'b0, 64'h0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    tests++;
    if (id_valid_o !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b expected 0", id_valid_o);
    end
    tests++;
    if (id_pc_o !== 64'h0) begin
      fails++; $display("FAIL reset_pc: got %h expected 0", id_pc_o);
    end
    tests++;
    if (id_instr_o !== 32'h0) begin
      fails++; $display("FAIL reset_instr: got %h expected 0", id_instr_o);
    end
`ifdef RV_FETCH_MISALIGN_EN
    tests++;
    if (misalign_o !== 1'b0) begin
      fails++; $display("FAIL reset_misalign: got %b expected 0", misalign_o);
    end
`endif
    // First cycle after release: RESET_PC requested, nothing valid yet.
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    tests++;
    if (imem_pc_o !== 64'h100) begin
      fails++; $display("FAIL release_imem_pc: got %h expected 100", imem_pc_o);
    end
    tests++;
    if (id_valid_o !== 1'b0) begin
      fails++; $display("FAIL release_valid: got %b expected 0", id_valid_o);
    end
    $display("[TB] reset and release checked");
  endtask

  task automatic test_stream();
    logic [63:0] e;
    for (int k = 0; k < 4; k++) begin
      e = 64'h100 + 64'(4 * k);
      drive(1'b0, 1'b1, 1'b0, 64'h0);
      tests++;
      if (id_valid_o !== 1'b1 || id_pc_o !== e || id_instr_o !== word_at(e)) begin
        fails++;
        $display("FAIL stream[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 k, id_valid_o, id_pc_o, id_instr_o, e, word_at(e));
      end
    end
    $display("[TB] stream 100..10c checked");
  endtask

  task automatic test_stall();
    logic [63:0] after [4];
    after = '{64'h104, 64'h108, 64'h10C, 64'h110};
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 64'h0);   // 0x100 transfers
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      tests++;
      if (id_valid_o !== 1'b1 || id_pc_o !== 64'h104 || id_instr_o !== word_at(64'h104)) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=104 instr=%h",
                 i, id_valid_o, id_pc_o, id_instr_o, word_at(64'h104));
      end
      if (i > 0) begin
        tests++;
        if (imem_pc_o !== 64'h108) begin
          fails++; $display("FAIL stall_replay[%0d]: got %h expected 108", i, imem_pc_o);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 64'h0);
      tests++;
      if (id_valid_o !== 1'b1 || id_pc_o !== after[i] || id_instr_o !== word_at(after[i])) begin
        fails++;
        $display("FAIL stall_resume[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 i, id_valid_o, id_pc_o, id_instr_o, after[i], word_at(after[i]));
      end
      if (i == 0) begin
        tests++;
        if (imem_pc_o !== 64'h10C) begin
          fails++; $display("FAIL stall_reissue: got %h expected 10c", imem_pc_o);
        end
      end
    end
    $display("[TB] 3-cycle stall on 104 checked");
  endtask

  task automatic test_back_to_back();
    logic [23:0] pat;
    logic [63:0] e;
    pat = 24'b1001_1101_0011_0100_0110_1101;
    e   = 64'h100;
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, pat[i], 1'b0, 64'h0);
      tests++;
      if (id_valid_o !== 1'b1 || id_pc_o !== e || id_instr_o !== word_at(e)) begin
        fails++;
        $display("FAIL b2b[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 i, id_valid_o, id_pc_o, id_instr_o, e, word_at(e));
      end
      if (pat[i]) e = e + 64'd4;
    end
    $display("[TB] ready pattern run checked, next pc %h", e);
  endtask

  task automatic test_redirect_stall();
    logic [63:0] e;
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 1'b0, 64'h0);   // hold=104, s1=108
    drive(1'b0, 1'b0, 1'b1, 64'h200);
    tests++;
    if (id_valid_o !== 1'b0 || imem_pc_o !== 64'h200) begin
      fails++;
      $display("FAIL redir_cycle: got v=%b imem=%h expected v=0 imem=200", id_valid_o, imem_pc_o);
    end
    for (int k = 0; k < 3; k++) begin
      e = 64'h200 + 64'(4 * k);
      drive(1'b0, 1'b1, 1'b0, 64'h0);
      tests++;
      if (id_valid_o !== 1'b1 || id_pc_o !== e || id_instr_o !== word_at(e)) begin
        fails++;
        $display("FAIL redir_after[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 k, id_valid_o, id_pc_o, id_instr_o, e, word_at(e));
      end
    end
    $display("[TB] redirect to 200 during stall checked");
  endtask

  task automatic test_wrap();
    logic [63:0] exp_pc [3];
    exp_pc = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};
    drive(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    tests++;
    if (imem_pc_o !== 64'hFFFF_FFFF_FFFF_FFFC || id_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL wrap_redir: got v=%b imem=%h expected v=0 imem=fffffffffffffffc",
               id_valid_o, imem_pc_o);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 64'h0);
      tests++;
      if (id_valid_o !== 1'b1 || id_pc_o !== exp_pc[k] || id_instr_o !== word_at(exp_pc[k])) begin
        fails++;
        $display("FAIL wrap[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, id_valid_o, id_pc_o, exp_pc[k]);
      end
    end
    $display("[TB] pc wrap-around checked");
  endtask

  task automatic test_reset_midstall();
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    tests++;
    if (id_valid_o !== 1'b0 || id_pc_o !== 64'h0 || id_instr_o !== 32'h0) begin
      fails++;
      $display("FAIL midstall_rst: got v=%b pc=%h instr=%h expected 0/0/0", id_valid_o, id_pc_o, id_instr_o);
    end
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    tests++;
    if (id_valid_o !== 1'b0 || imem_pc_o !== 64'h100) begin
      fails++;
      $display("FAIL midstall_release: got v=%b imem=%h expected v=0 imem=100", id_valid_o, imem_pc_o);
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    tests++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 64'h100) begin
      fails++; $display("FAIL midstall_first: got v=%b pc=%h expected v=1 pc=100", id_valid_o, id_pc_o);
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    tests++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 64'h104) begin
      fails++; $display("FAIL midstall_second: got v=%b pc=%h expected v=1 pc=104", id_valid_o, id_pc_o);
    end
    $display("[TB] reset during stall checked");
  endtask

`ifdef RV_FETCH_MISALIGN_EN
  task automatic test_misalign();
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 64'h0);   // 0x100 transfers, pc_q now 0x108
    drive(1'b0, 1'b1, 1'b1, 64'h202);
    tests++;
    if (id_valid_o !== 1'b0 || misalign_o !== 1'b0) begin
      fails++; $display("FAIL mis_redir: got v=%b mis=%b expected 0/0", id_valid_o, misalign_o);
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    tests++;
    if (misalign_o !== 1'b1 || id_valid_o !== 1'b0 || imem_pc_o !== 64'h108) begin
      fails++;
      $display("FAIL mis_pulse: got mis=%b v=%b imem=%h expected 1/0/108", misalign_o, id_valid_o, imem_pc_o);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 64'h0);
      tests++;
      if (misalign_o !== 1'b0 || id_valid_o !== 1'b0 || imem_pc_o !== 64'h108) begin
        fails++;
        $display("FAIL mis_halt[%0d]: got mis=%b v=%b imem=%h expected 0/0/108",
                 i, misalign_o, id_valid_o, imem_pc_o);
      end
    end
    drive(1'b0, 1'b1, 1'b1, 64'h300);
    tests++;
    if (id_valid_o !== 1'b0 || imem_pc_o !== 64'h300) begin
      fails++; $display("FAIL mis_recover: got v=%b imem=%h expected 0/300", id_valid_o, imem_pc_o);
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    tests++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 64'h300) begin
      fails++; $display("FAIL mis_resume0: got v=%b pc=%h expected 1/300", id_valid_o, id_pc_o);
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    tests++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 64'h304) begin
      fails++; $display("FAIL mis_resume1: got v=%b pc=%h expected 1/304", id_valid_o, id_pc_o);
    end
    $display("[TB] misaligned redirect halt checked");
  endtask
`else
  task automatic test_align_force();
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    drive(1'b0, 1'b1, 1'b1, 64'h20B);
    tests++;
    if (id_valid_o !== 1'b0 || imem_pc_o !== 64'h208) begin
      fails++; $display("FAIL align_redir: got v=%b imem=%h expected 0/208", id_valid_o, imem_pc_o);
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    tests++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 64'h208) begin
      fails++; $display("FAIL align_first: got v=%b pc=%h expected 1/208", id_valid_o, id_pc_o);
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    tests++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 64'h20C) begin
      fails++; $display("FAIL align_second: got v=%b pc=%h expected 1/20c", id_valid_o, id_pc_o);
    end
    $display("[TB] redirect alignment masking checked");
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_redirect_stall();
    test_wrap();
    test_reset_midstall();
`ifdef RV_FETCH_MISALIGN_EN
    test_misalign();
`else
    test_align_force();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
